// File: rtl/coin_acceptor_pkg.sv
// Shared vending package: coin codes used by the acceptor
// and by the downstream vending FSM.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_FIVE = 2'b01,
    COIN_TEN  = 2'b10
  } coin_t;

  function automatic coin_t coin_code(input logic five);
    return five ? COIN_FIVE : COIN_TEN;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Acceptor -> vending FSM bus: accept_en (in), coin code,
// reject pulse and queue occupancy count (out).
interface coin_acceptor_if;
  import coin_acceptor_pkg::*;

  logic       accept_en;
  coin_t      coin;
  logic       reject;
  logic [3:0] count;

  modport master (
    input  accept_en,
    output coin,
    output reject,
    output count
  );

  modport slave (
    output accept_en,
    input  coin,
    input  reject,
    input  count
  );

endinterface

// File: rtl/coin_debounce.sv
// One sensor line: 2-flop sync, debounce counter, arming, edge.
// Ports: clk, rst, raw (async line), evt (1-cycle coin event).
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);

  localparam logic [3:0] DMAX = 4'(DEBOUNCE_CYCLES);

  logic       s1, s2;
  logic       v1, v2;
  logic       armed;
  logic       lvl;
  logic       lvl_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;

  // counter saturates at DMAX so a long pulse holds the level
  always_comb begin
    cnt_nx = '0;
    if (s2)
      cnt_nx = (cnt == DMAX) ? cnt : cnt + 4'd1;
  end

  assign lvl_nx = s2 && (cnt_nx == DMAX);

  // v1/v2 mark sync stages holding a real sample rather than
  // the reset value; only a real low sample arms the line
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      armed <= 1'b0;
      evt   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      v1    <= 1'b1;
      v2    <= v1;
      cnt   <= cnt_nx;
      lvl   <= lvl_nx;
      armed <= armed | (v2 & ~s2);
      evt   <= armed & lvl_nx & ~lvl;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced sensors feed a coin FIFO that an
// output FSM drains one coin per IDLE->EMIT->GAP round.
// Ports: clk, rst, coin5_raw, coin10_raw, bus (master side).
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            coin5_raw,
  input  logic            coin10_raw,
  coin_acceptor_if.master bus
);

  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] FULL  = 4'(FIFO_DEPTH);
  localparam logic [2:0] GLAST = 3'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state;
  coin_t         coin_q;
  logic          reject_q;
  logic [3:0]    count_q;
  logic [AW-1:0] wp, rp;
  logic [2:0]    gcnt;
  coin_t         mem [FIFO_DEPTH];

  logic e5, e10;
  logic single;
  logic push, pop;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk (clk),
    .rst (rst),
    .raw (coin5_raw),
    .evt (e5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk (clk),
    .rst (rst),
    .raw (coin10_raw),
    .evt (e10)
  );

  // fullness is judged on the pre-pop count
  assign single = e5 ^ e10;
  assign push   = single && (count_q != FULL);
  assign pop    = (state == S_IDLE) && bus.accept_en
               && (count_q != 4'd0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= coin_code(e5);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      count_q  <= '0;
      wp       <= '0;
      rp       <= '0;
      gcnt     <= '0;
    end else begin
      reject_q <= (e5 & e10) | (single & ~push);
      count_q  <= count_q + {3'b0, push} - {3'b0, pop};
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      unique case (state)
        S_IDLE: begin
          coin_q <= COIN_NONE;
          if (pop) begin
            coin_q <= mem[rp];
            state  <= S_EMIT;
          end
        end
        S_EMIT: begin
          coin_q <= COIN_NONE;
          gcnt   <= GLAST;
          state  <= S_GAP;
        end
        S_GAP: begin
          coin_q <= COIN_NONE;
          if (gcnt == 3'd0)
            state <= S_IDLE;
          else
            gcnt <= gcnt - 3'd1;
        end
        default: begin
          coin_q <= COIN_NONE;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.coin   = coin_q;
  assign bus.reject = reject_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters.
// Negedge monitor tallies coin/reject pulses and coin times.
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin5_raw = 1'b0;
  logic coin10_raw = 1'b0;

  coin_acceptor_if bus();

  coin_acceptor dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n5 = 0;
  int n10 = 0;
  int nrej = 0;
  int nbad = 0;
  int tq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.coin == COIN_FIVE) n5++;
    if (bus.coin == COIN_TEN) n10++;
    if (bus.coin == COIN_NONE) ;
    else if (bus.coin != COIN_FIVE && bus.coin != COIN_TEN)
      nbad++;
    if (bus.coin != COIN_NONE) tq.push_back(cyc);
    if (bus.reject) nrej++;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int last_t();
    return (tq.size() > 0) ? tq[tq.size()-1] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b5, b10, br, e0, tb0, seen;
    int pat[5];
    pat = '{1, 0, 1, 1, 0};
    bus.accept_en = 1'b1;

    // reset state
    tick(3);
    chk("rst_coin", int'(bus.coin), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_count", int'(bus.count), 0);
    rst = 1'b0;
    tick(6);

    // single Rs.5 coin, latency 7 from first high sample
    b5 = n5; br = nrej;
    coin5_raw = 1'b1;
    e0 = cyc + 1;
    tick(10);
    coin5_raw = 1'b0;
    tick(15);
    chk("t1_n5", n5 - b5, 1);
    chk("t1_latency", last_t() - e0, 7);
    chk("t1_reject", nrej - br, 0);
    chk("t1_count", int'(bus.count), 0);

    // bouncy Rs.10 then stable high
    b10 = n10; br = nrej;
    foreach (pat[i]) begin
      coin10_raw = pat[i][0];
      tick(1);
    end
    coin10_raw = 1'b1;
    tick(8);
    coin10_raw = 1'b0;
    tick(15);
    chk("t2_n10", n10 - b10, 1);
    chk("t2_reject", nrej - br, 0);

    // both lines together: ambiguous, rejected
    b5 = n5; b10 = n10; br = nrej;
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    tick(10);
    chk("t3_count_mid", int'(bus.count), 0);
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    tick(15);
    chk("t3_reject", nrej - br, 1);
    chk("t3_coins", (n5 - b5) + (n10 - b10), 0);
    chk("t3_count", int'(bus.count), 0);

    // fill queue with accept_en low, fifth coin rejected
    bus.accept_en = 1'b0;
    b10 = n10; br = nrej;
    for (int k = 1; k <= 5; k++) begin
      coin10_raw = 1'b1;
      tick(6);
      coin10_raw = 1'b0;
      tick(6);
      chk($sformatf("t4_count%0d", k), int'(bus.count),
          (k < 5) ? k : 4);
    end
    chk("t4_reject", nrej - br, 1);
    chk("t4_held", n10 - b10, 0);
    tb0 = tq.size();
    bus.accept_en = 1'b1;
    tick(25);
    chk("t4_drain", n10 - b10, 4);
    chk("t4_count_end", int'(bus.count), 0);
    // one coin every 4 cycles: 3 idle cycles between coins
    for (int i = 0; i < 3; i++)
      chk($sformatf("t4_spacing%0d", i),
          (tq.size() >= tb0 + 4) ? tq[tb0+i+1] - tq[tb0+i] : -1,
          4);

    // line held high through reset release is ignored
    b5 = n5; br = nrej;
    coin5_raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(12);
    chk("t5_held_high", n5 - b5, 0);
    coin5_raw = 1'b0;
    tick(4);
    coin5_raw = 1'b1;
    tick(6);
    coin5_raw = 1'b0;
    tick(15);
    chk("t5_second", n5 - b5, 1);
    chk("t5_reject", nrej - br, 0);

    // reset during EMIT with coins queued
    bus.accept_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      coin5_raw = 1'b1;
      tick(6);
      coin5_raw = 1'b0;
      tick(6);
    end
    chk("t6_count3", int'(bus.count), 3);
    bus.accept_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick(1);
      if (bus.coin != COIN_NONE) seen = 1;
    end
    chk("t6_emit_seen", seen, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_coin", int'(bus.coin), 0);
    chk("t6_rst_count", int'(bus.count), 0);
    chk("t6_rst_reject", int'(bus.reject), 0);
    b5 = n5; br = nrej;
    tick(1);
    rst = 1'b0;
    tick(20);
    chk("t6_no_more", n5 - b5, 0);
    chk("t6_no_reject", nrej - br, 0);
    chk("t6_count_end", int'(bus.count), 0);
    chk("code_11_never", nbad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
